alu_sequencer: RTL

- Multi-cycle execute/write-back stage for the 8 x 16 register file.
- Accepts one 16-bit instruction per start handshake and drives the register file read addresses (RdAdrsA, RdAdrsB).
- Captures the returned operands (OperA, OperB) and computes the result, with an iterative shift-add multiply.
- Writes the result back by pulsing the write and step controls, which the register file qualifies as step & write.

---
 rtl/alu_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle execute/write-back stage for an 8 x W register file.
// Ports: clk, rst (async active-low); start/instr issue one instruction while idle;
// busy/done report progress; RdAdrsA/RdAdrsB address the register file and
// OperA/OperB return its data; WtAdrs/WtData/write/step perform the write-back;
// flag_z/flag_c are the zero and carry/borrow/overflow flags.
module alu_sequencer #(
  parameter int W       = 16,
  parameter int AW      = 3,
  parameter int MUL_CYC = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   instr,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] RdAdrsA,
  output logic [AW-1:0] RdAdrsB,
  input  logic [W-1:0]  OperA,
  input  logic [W-1:0]  OperB,
  output logic [AW-1:0] WtAdrs,
  output logic [W-1:0]  WtData,
  output logic          write,
  output logic          step,
  output logic          flag_z,
  output logic          flag_c
);
  localparam int CW = $clog2(MUL_CYC);
  typedef enum logic [2:0] {IDLE, READ, EXEC, MUL, WB} state_t;
  state_t state_q, state_d;
  logic [3:0] opc_q;
  logic [2:0] sh_q;
  logic [AW-1:0] rda_q, rdb_q, wta_q;
  logic [W-1:0] opa_q, opb_q, wtd_q;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q;
  logic busy_q, z_q, c_q;
  logic [W:0] ext_d, shr_d, sum_d;
  logic mul_last;
  assign mul_last = cnt_q == CW'(MUL_CYC - 1);
  // Right-shift shift-add: the upper half accumulates, the lower half starts as
  // the multiplier and is consumed one bit per cycle from the LSB.
  assign sum_d = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opa_q} : '0);
  assign acc_d = {sum_d, acc_q[W-1:1]};
  // Shifting A with a guard bit below it leaves the last bit shifted out in bit 0.
  assign shr_d = {opa_q, 1'b0} >> sh_q;
  // ext_d[W] carries the C flag; it is 0 for the pure logic ops.
  always_comb begin
    ext_d = '0;
    case (opc_q)
      4'd0:        ext_d = {1'b0, opa_q} + {1'b0, opb_q};
      4'd1, 4'd10: ext_d = {1'b0, opa_q} - {1'b0, opb_q};
      4'd2:        ext_d = {1'b0, opa_q & opb_q};
      4'd3:        ext_d = {1'b0, opa_q | opb_q};
      4'd4:        ext_d = {1'b0, opa_q ^ opb_q};
      4'd5:        ext_d = {1'b0, ~opa_q};
      4'd6:        ext_d = {1'b0, opa_q} << sh_q;
      4'd7:        ext_d = {shr_d[0], shr_d[W:1]};
      4'd8:        ext_d = {1'b0, opa_q};
      default:     ext_d = '0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? READ : IDLE;
      READ:    state_d = opc_q == 4'd9 ? MUL : EXEC;
      EXEC:    state_d = WB;
      MUL:     state_d = mul_last ? WB : MUL;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      opc_q   <= '0;
      sh_q    <= '0;
      rda_q   <= '0;
      rdb_q   <= '0;
      wta_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      wtd_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        opc_q  <= instr[15:12];
        wta_q  <= AW'(instr[11:9]);
        rda_q  <= AW'(instr[8:6]);
        rdb_q  <= AW'(instr[5:3]);
        sh_q   <= instr[2:0];
        busy_q <= 1'b1;
      end
      if (state_q == READ) begin
        opa_q <= OperA;
        opb_q <= OperB;
        acc_q <= {{W{1'b0}}, OperB};
        cnt_q <= '0;
      end
      if (state_q == MUL) begin
        acc_q <= acc_d;
        cnt_q <= cnt_q + 1'b1;
        if (mul_last) begin
          wtd_q <= acc_d[W-1:0];
          z_q   <= acc_d[W-1:0] == '0;
          c_q   <= |acc_d[2*W-1:W];
        end
      end
      // CMP updates flags only; NOPs leave both flags and data untouched.
      if (state_q == EXEC && opc_q <= 4'd10) begin
        z_q <= ext_d[W-1:0] == '0;
        c_q <= ext_d[W];
        if (opc_q != 4'd10) wtd_q <= ext_d[W-1:0];
      end
      if (state_q == WB) busy_q <= 1'b0;
    end
  end
  assign busy    = busy_q;
  assign done    = state_q == WB;
  assign write   = done && opc_q <= 4'd9;
  assign step    = write;
  assign RdAdrsA = rda_q;
  assign RdAdrsB = rdb_q;
  assign WtAdrs  = wta_q;
  assign WtData  = wtd_q;
  assign flag_z  = z_q;
  assign flag_c  = c_q;
endmodule
